spi_stream_receiver: RTL and testbench
======================================

Name: spi_stream_receiver

Overview:
Parametrised successor to the team's single-byte SPI shift buffer. It is clocked directly by the SPI serial clock. It detects the card-style power-up sequence: a run of INIT_CLOCKS consecutive DI=1 cycles. It then frames back-to-back words of WORD_WIDTH bits, starting on a start bit, and queues each completed word in a DEPTH-entry show-ahead FIFO. The consumer in the same clock domain drains the FIFO through a valid/ready handshake.

Parameters:
WORD_WIDTH, 8, bits per received word (2..32)
DEPTH, 4, FIFO entries (power of two, 2..16)
INIT_CLOCKS, 74, consecutive DI=1 cycles needed before framing is armed (1..255)
LSB_FIRST, 0, 0 = first received bit is the word MSB; 1 = first received bit is the word LSB

Ports:
CLK  in  1  SPI serial clock; all logic on rising edge
RST_N  in  1  asynchronous active-low reset
DI  in  1  serial data in
CS  in  1  chip select, active-low (high = deselected)
RX_DATA  out  WORD_WIDTH  FIFO head word; all-ones when empty
RX_VALID  out  1  FIFO non-empty
RX_READY  in  1  consumer accepts head when RX_VALID=1
LEVEL  out  $clog2(DEPTH)+1  FIFO occupancy
OVERFLOW  out  1  sticky; a completed word was dropped
CLR_OVF  in  1  clears OVERFLOW
INIT_DONE  out  1  sticky; init run seen
BUSY  out  1  a word is partially shifted in

Behaviour:
- Reset (RST_N=0, async):
  - state=INIT, init count=0, bit count=0, shift register all-ones.
  - FIFO empty, LEVEL=0, RX_VALID=0, RX_DATA all-ones.
  - OVERFLOW=0, INIT_DONE=0, BUSY=0.
- State INIT (counting is independent of CS):
  - DI=1: count increments, saturating at INIT_CLOCKS.
  - DI=0: count returns to 0.
  - The cycle in which count reaches INIT_CLOCKS: INIT_DONE=1 from the next cycle; state -> ARMED.
  - DI values seen in INIT are never shifted into a word.
- State ARMED:
  - CS=1: no change.
  - CS=0 and DI=0: start bit. It is captured as bit 1 of the word; bit count=1; state -> RECV; BUSY=1.
  - CS=0 and DI=1: ignored.
- State RECV (CS=0): each cycle shifts DI in and increments the bit count.
  - Bit order: LSB_FIRST=0 shifts left (new bit at LSB). LSB_FIRST=1 shifts right (new bit at MSB).
  - On bit WORD_WIDTH the completed word (including that cycle's DI) is pushed to the FIFO.
  - After the push the bit count wraps to 0 and the state stays RECV. The next cycle's DI is bit 1 of the next word; no start bit is needed between words.
  - BUSY=1 whenever bit count != 0.
- CS=1 in RECV or ARMED:
  - The partial word is discarded; bit count=0; shift register all-ones; BUSY=0; state -> ARMED.
  - FIFO contents, INIT_DONE and OVERFLOW are kept.
  - A word whose last bit arrives in the same cycle CS rises is discarded.
- FIFO:
  - Show-ahead: RX_DATA is valid combinationally whenever RX_VALID=1.
  - Pop when RX_VALID && RX_READY.
  - Push latency: a word completed at edge N appears on RX_DATA/RX_VALID after edge N (one cycle).
  - Empty: RX_READY is ignored and LEVEL stays 0.
  - Full with push and no pop: the word is dropped, LEVEL stays DEPTH, OVERFLOW=1 next cycle.
  - Full with push and pop in the same cycle: both happen, LEVEL unchanged, no overflow.
  - Pointers wrap modulo DEPTH.
- OVERFLOW:
  - CLR_OVF=1 clears it next cycle.
  - If CLR_OVF and a new drop occur in the same cycle, the set wins (OVERFLOW=1).
- Width rules:
  - Init counter width is $clog2(INIT_CLOCKS+1).
  - Bit counter width is $clog2(WORD_WIDTH+1).
  - LEVEL never exceeds DEPTH.
- Async reset mid-word or mid-init returns every output to its reset value immediately, not on the next clock edge.

Test Plan:
- Init gate: 73 cycles of DI=1, one DI=0, then 74 cycles of DI=1 -> INIT_DONE rises only after the 74th consecutive 1; the earlier 0-bits never produce words.
- Byte stream, defaults: after init, CS=0, shift 0x40,0x00,0x00,0x00,0x00,0x95 MSB-first -> six FIFO entries, RX_DATA=0x40 first, LEVEL=4 with OVERFLOW=1 if RX_READY=0 (last two bytes dropped).
- Handshake: RX_READY held 1 during the same stream -> each byte appears one cycle after its last bit and pops the same cycle; LEVEL never exceeds 1; OVERFLOW=0.
- LSB_FIRST=1, WORD_WIDTH=12: shift bits 0,1,1,0,0,0,0,0,0,0,0,1 -> RX_DATA=0x806.
- CS abort: raise CS after 5 bits of a word, drop CS, send 0x3C -> only 0x3C is queued; BUSY=0 during the CS-high cycle; INIT_DONE stays 1.
- Full boundary and reset: DEPTH=4 full, push and pop in the same cycle -> LEVEL=4, no overflow; CLR_OVF coincident with a drop -> OVERFLOW=1; RST_N low mid-word -> LEVEL=0, INIT_DONE=0, RX_DATA all-ones asynchronously.

Source files
------------

// File: rtl/spi_stream_receiver.sv
// rtl/spi_stream_receiver.sv - SPI-clocked init detector, word framer and show-ahead receive FIFO
module spi_stream_receiver #(
    parameter int WORD_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int INIT_CLOCKS = 74,
    parameter int LSB_FIRST   = 0
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       DI,
    input  logic                       CS,
    output logic [WORD_WIDTH-1:0]      RX_DATA,
    output logic                       RX_VALID,
    input  logic                       RX_READY,
    output logic [$clog2(DEPTH):0]     LEVEL,
    output logic                       OVERFLOW,
    input  logic                       CLR_OVF,
    output logic                       INIT_DONE,
    output logic                       BUSY
);

    localparam int IW = $clog2(INIT_CLOCKS + 1);
    localparam int BW = $clog2(WORD_WIDTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [IW-1:0] INIT_MAX  = IW'(INIT_CLOCKS);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CLOCKS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_WIDTH - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RECV  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         init_cnt_q, init_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [WORD_WIDTH-1:0] shift_in;
    logic                  init_done_q, init_done_d;
    logic                  init_reach;
    logic                  push_req;

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  full, pop, push_ok, drop;

    // The next bit folds in at the LSB (MSB-first words) or at the MSB (LSB-first words)
    always_comb begin
        if (LSB_FIRST != 0) begin
            shift_in = {DI, shift_q[WORD_WIDTH-1:1]};
        end else begin
            shift_in = {shift_q[WORD_WIDTH-2:0], DI};
        end
    end

    assign init_reach = DI && (init_cnt_q == INIT_LAST);

    // Framer state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Framer next-state: init run arms framing, a low start bit opens a word, CS high aborts
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (init_reach) state_d = ST_ARMED;
            ST_ARMED: if (!CS && !DI) state_d = ST_RECV;
            ST_RECV:  if (CS) state_d = ST_ARMED;
            default:  state_d = ST_INIT;
        endcase
    end

    // Framer outputs: counters, shift register and the word-complete push request
    always_comb begin
        init_cnt_d  = init_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        init_done_d = init_done_q;
        push_req    = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (!DI) begin
                    init_cnt_d = '0;
                end else if (init_cnt_q != INIT_MAX) begin
                    init_cnt_d = init_cnt_q + IW'(1);
                end
                if (init_reach) init_done_d = 1'b1;
            end
            ST_ARMED: begin
                if (CS) begin
                    bit_cnt_d = '0;
                    shift_d   = '1;
                end else if (!DI) begin
                    shift_d   = shift_in;
                    bit_cnt_d = BW'(1);
                end
            end
            ST_RECV: begin
                if (CS) begin
                    bit_cnt_d = '0;
                    shift_d   = '1;
                end else begin
                    shift_d = shift_in;
                    if (bit_cnt_q == BIT_LAST) begin
                        push_req  = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Framer datapath registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            init_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '1;
            init_done_q <= 1'b0;
        end else begin
            init_cnt_q  <= init_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            init_done_q <= init_done_d;
        end
    end

    // A full FIFO still accepts a word when the head is popped in the same cycle
    assign full    = (count_q == FULL_LVL);
    assign pop     = RX_VALID && RX_READY;
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    // Occupancy and sticky overflow; a fresh drop beats a coincident clear
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO pointers, occupancy and overflow flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage; contents are only observable through a valid head, so no reset
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr_q] <= shift_in;
    end

    assign RX_VALID  = (count_q != '0);
    assign RX_DATA   = RX_VALID ? mem[rd_ptr_q] : '1;
    assign LEVEL     = count_q;
    assign OVERFLOW  = ovf_q;
    assign INIT_DONE = init_done_q;
    assign BUSY      = (bit_cnt_q != '0);

endmodule

// File: tb/tb_spi_stream_receiver.sv
// tb/tb_spi_stream_receiver.sv - directed self-checking bench for spi_stream_receiver
module tb_spi_stream_receiver;

    logic        clk;
    logic        rst_n;
    logic        di, cs, rx_ready, clr_ovf;
    logic [7:0]  rx_data;
    logic        rx_valid, overflow, init_done, busy;
    logic [2:0]  level;

    logic        di2, cs2, rx_ready2, clr_ovf2;
    logic [11:0] rx_data2;
    logic        rx_valid2, overflow2, init_done2, busy2;
    logic [1:0]  level2;

    int errors = 0;
    int checks = 0;
    int max_lvl = 0;

    spi_stream_receiver #(
        .WORD_WIDTH(8), .DEPTH(4), .INIT_CLOCKS(74), .LSB_FIRST(0)
    ) u_dut (
        .CLK(clk), .RST_N(rst_n), .DI(di), .CS(cs),
        .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(rx_ready),
        .LEVEL(level), .OVERFLOW(overflow), .CLR_OVF(clr_ovf),
        .INIT_DONE(init_done), .BUSY(busy)
    );

    spi_stream_receiver #(
        .WORD_WIDTH(12), .DEPTH(2), .INIT_CLOCKS(3), .LSB_FIRST(1)
    ) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .DI(di2), .CS(cs2),
        .RX_DATA(rx_data2), .RX_VALID(rx_valid2), .RX_READY(rx_ready2),
        .LEVEL(level2), .OVERFLOW(overflow2), .CLR_OVF(clr_ovf2),
        .INIT_DONE(init_done2), .BUSY(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (int'(level) > max_lvl) max_lvl = int'(level);
    endtask

    task automatic send_bit(input logic b);
        di = b;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    logic [7:0] stream [6] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    logic       bits2 [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] b55 = 8'h55;
    logic [7:0] b66 = 8'h66;

    initial begin
        rst_n = 1'b0; di = 1'b0; cs = 1'b1; rx_ready = 1'b0; clr_ovf = 1'b0;
        di2 = 1'b0; cs2 = 1'b1; rx_ready2 = 1'b0; clr_ovf2 = 1'b0;
        #12;
        check("rst_rx_data", 32'(rx_data), 32'hFF);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // init gate with CS low: a broken run must restart the count
        cs = 1'b0;
        repeat (73) send_bit(1'b1);
        send_bit(1'b0);
        repeat (73) send_bit(1'b1);
        check("init_before_74", 32'(init_done), 32'd0);
        check("init_no_words", 32'(level), 32'd0);
        send_bit(1'b1);
        check("init_after_74", 32'(init_done), 32'd1);
        send_bit(1'b1);
        send_bit(1'b1);
        check("armed_ignores_ones", 32'(busy), 32'd0);

        // byte stream with consumer stalled
        send_bit(1'b0);
        check("start_bit_busy", 32'(busy), 32'd1);
        send_bit(1'b1);
        for (int i = 5; i >= 0; i--) send_bit(1'b0);
        check("first_word_head", 32'(rx_data), 32'h40);
        check("first_word_level", 32'(level), 32'd1);
        for (int k = 1; k < 6; k++) send_byte(stream[k]);
        check("stall_level", 32'(level), 32'd4);
        check("stall_overflow", 32'(overflow), 32'd1);
        check("stall_head", 32'(rx_data), 32'h40);
        check("stall_busy_idle", 32'(busy), 32'd0);
        cs = 1'b1;
        rx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_order", 32'(rx_data), 32'(stream[k]));
            tick();
        end
        check("drained_valid", 32'(rx_valid), 32'd0);
        check("drained_data", 32'(rx_data), 32'hFF);
        tick();
        check("empty_ready_ignored", 32'(level), 32'd0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf", 32'(overflow), 32'd0);

        // same stream with consumer always ready
        max_lvl = 0;
        cs = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send_byte(stream[k]);
            check("hs_head", 32'(rx_data), 32'(stream[k]));
            check("hs_valid", 32'(rx_valid), 32'd1);
        end
        cs = 1'b1;
        tick();
        check("hs_level_end", 32'(level), 32'd0);
        check("hs_max_level", 32'(max_lvl), 32'd1);
        check("hs_overflow", 32'(overflow), 32'd0);

        // CS abort mid-word
        rx_ready = 1'b0;
        cs = 1'b0;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check("abort_busy_before", 32'(busy), 32'd1);
        cs = 1'b1;
        tick();
        check("abort_busy_cs_high", 32'(busy), 32'd0);
        check("abort_init_kept", 32'(init_done), 32'd1);
        check("abort_no_word", 32'(level), 32'd0);
        cs = 1'b0;
        send_byte(8'h3C);
        check("abort_level", 32'(level), 32'd1);
        check("abort_word", 32'(rx_data), 32'h3C);
        cs = 1'b1;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("abort_popped", 32'(level), 32'd0);

        // LSB-first 12-bit instance
        di2 = 1'b1;
        repeat (3) tick();
        check("dut2_init", 32'(init_done2), 32'd1);
        cs2 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            di2 = bits2[i];
            tick();
        end
        check("dut2_word", 32'(rx_data2), 32'h806);
        check("dut2_valid", 32'(rx_valid2), 32'd1);
        cs2 = 1'b1;

        // full boundary
        cs = 1'b0;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("full_level", 32'(level), 32'd4);
        check("full_no_ovf", 32'(overflow), 32'd0);
        for (int i = 7; i >= 1; i--) send_bit(b55[i]);
        rx_ready = 1'b1;
        send_bit(b55[0]);
        rx_ready = 1'b0;
        check("push_pop_level", 32'(level), 32'd4);
        check("push_pop_no_ovf", 32'(overflow), 32'd0);
        check("push_pop_head", 32'(rx_data), 32'h22);
        for (int i = 7; i >= 1; i--) send_bit(b66[i]);
        clr_ovf = 1'b1;
        send_bit(b66[0]);
        clr_ovf = 1'b0;
        check("set_beats_clear", 32'(overflow), 32'd1);
        check("drop_level", 32'(level), 32'd4);
        rx_ready = 1'b1;
        send_bit(1'b1);
        rx_ready = 1'b0;
        check("after_pop_head", 32'(rx_data), 32'h33);
        check("after_pop_level", 32'(level), 32'd3);
        send_bit(1'b0);
        send_bit(1'b1);
        check("midword_busy", 32'(busy), 32'd1);

        // asynchronous reset mid-word, checked before any clock edge
        rst_n = 1'b0;
        #1;
        check("async_level", 32'(level), 32'd0);
        check("async_init_done", 32'(init_done), 32'd0);
        check("async_rx_data", 32'(rx_data), 32'hFF);
        check("async_valid", 32'(rx_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_overflow", 32'(overflow), 32'd0);
        check("async_dut2_init", 32'(init_done2), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
